// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: key-byte queue between the PS/2 receiver and the LCD writer.
// Optionally strips PS/2 break (F0 xx) and extended (E0) prefix codes, then
// buffers up to 2**ADDR_W bytes behind a first-word-fall-through valid/ready
// output so slow consumers never lose keystrokes.
// Ports:
//   clock, resetn           clock and synchronous active-low reset
//   in_data, in_valid       incoming key byte and its one-cycle strobe
//   out_data, out_valid     registered head of queue (0 when empty) and its valid
//   out_ready               consumer accepts head when out_valid & out_ready
//   count, full, empty      registered fill level and status flags
//   overflow                sticky flag: a byte was dropped on a full queue
//   clear_overflow          one-cycle pulse clearing overflow (set wins)
module ps2_key_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned FILTER_BREAK = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  typedef enum logic {
    F_IDLE,
    F_SKIP
  } filt_state_t;

  filt_state_t           state, state_nxt;
  logic                  push_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  pop_c, wr_en_c, drop_c;

  // Filter state register
  always_ff @(posedge clock) begin
    if (!resetn) state <= F_IDLE;
    else         state <= state_nxt;
  end

  // Filter next-state and push decision; advances on every in_valid, even when full
  always_comb begin
    state_nxt = state;
    push_c    = 1'b0;
    if (FILTER_BREAK == 0) begin
      state_nxt = F_IDLE;
      push_c    = in_valid;
    end else if (in_valid) begin
      case (state)
        F_IDLE: begin
          if (in_data[7:0] == 8'hF0)      state_nxt = F_SKIP;
          else if (in_data[7:0] != 8'hE0) push_c    = 1'b1;
        end
        F_SKIP:  state_nxt = F_IDLE;  // released-key byte (or repeated F0) dropped
        default: state_nxt = F_IDLE;
      endcase
    end
  end

  // Queue control; a push onto a full queue is accepted only if the head leaves
  always_comb begin
    pop_c   = out_valid & out_ready;
    wr_en_c = push_c & (~full | pop_c);
    drop_c  = push_c & full & ~pop_c;
    rd_nxt  = pop_c   ? rd_ptr + ADDR_W'(1) : rd_ptr;
    wr_nxt  = wr_en_c ? wr_ptr + ADDR_W'(1) : wr_ptr;
    case ({wr_en_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    // Next head: the byte being written lands in the head slot only when the
    // queue is (or becomes) otherwise empty
    if (count_nxt == '0)                  head_nxt = '0;
    else if (wr_en_c && wr_ptr == rd_nxt) head_nxt = in_data;
    else                                  head_nxt = mem[rd_nxt];
  end

  // Storage array
  always_ff @(posedge clock) begin
    if (resetn && wr_en_c) mem[wr_ptr] <= in_data;
  end

  // Pointers, status and registered head
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
      out_valid <= (count_nxt != '0);
      out_data  <= head_nxt;
      if (drop_c)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Scoreboard bench for ps2_key_fifo with default parameters (8-bit, depth 16, filtering on).
module tb_ps2_key_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clear_overflow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];

  ps2_key_fifo dut (
    .clock          (clock),
    .resetn         (resetn),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    in_data   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    if (accept) sb.push_back(b);
    cycle();
    in_valid = 1'b0;
  endtask

  // Pop everything the scoreboard expects, comparing order, then confirm empty
  task automatic drain(input string tag);
    int budget = 100;
    out_ready = 1'b1;
    while (sb.size() > 0 && budget > 0) begin
      if (out_valid) begin
        n_vec++;
        if (out_data !== sb[0]) begin
          n_err++;
          $display("FAIL %s_drain: out_data=%h required %h", tag, out_data, sb[0]);
        end
        void'(sb.pop_front());
      end
      budget--;
      cycle();
    end
    out_ready = 1'b0;
    n_vec++;
    if (budget == 0 || empty !== 1'b1 || out_valid !== 1'b0 || count !== 5'd0) begin
      n_err++;
      $display("FAIL %s_empty: empty=%b out_valid=%b count=%0d left=%0d required 1/0/0/0",
               tag, empty, out_valid, count, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    push_byte(8'h55, 1'b0);
    push_byte(8'h66, 1'b0);
    push_byte(8'h77, 1'b0);
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    cycle();
    cycle();
    resetn   = 1'b1;
    in_valid = 1'b0;
    n_vec++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
        overflow !== 1'b0 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset: count=%0d empty=%b full=%b out_valid=%b overflow=%b out_data=%h required 0/1/0/0/0/00",
               count, empty, full, out_valid, overflow, out_data);
    end
    // F0 seen during reset must not leave the filter in skip state
    push_byte(8'h21, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h21 || count !== 5'd1) begin
      n_err++;
      $display("FAIL reset_first_push: out_valid=%b out_data=%h count=%0d required 1/21/1",
               out_valid, out_data, count);
    end
    drain("reset");
  endtask

  task automatic test_filter();
    logic [7:0] stream [7] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hF0, 8'hE0};
    bit         keep   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) push_byte(stream[i], keep[i]);
    n_vec++;
    if (count !== 5'd2 || out_data !== 8'h1C) begin
      n_err++;
      $display("FAIL filter_count: count=%0d head=%h required 2/1C", count, out_data);
    end
    // F0 then E0 returns to idle, so the next byte is kept
    push_byte(8'h33, 1'b1);
    n_vec++;
    if (count !== 5'd3) begin
      n_err++;
      $display("FAIL filter_idle: count=%0d required 3", count);
    end
    drain("filter");
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    n_vec++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fill: full=%b count=%0d overflow=%b required 1/16/0", full, count, overflow);
    end
    push_byte(8'h10, 1'b0);
    n_vec++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL overflow: full=%b count=%0d overflow=%b head=%h required 1/16/1/00",
               full, count, overflow, out_data);
    end
  endtask

  task automatic test_full_push_pop();
    in_data   = 8'hAA;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== sb[0]) begin
      n_err++;
      $display("FAIL fullpp_head: out_data=%h required %h", out_data, sb[0]);
    end
    void'(sb.pop_front());
    sb.push_back(8'hAA);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1 || out_data !== 8'h01) begin
      n_err++;
      $display("FAIL fullpp: count=%0d full=%b overflow=%b head=%h required 16/1/1/01",
               count, full, overflow, out_data);
    end
    drain("fullpp");
  endtask

  task automatic test_clear_overflow();
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_pre: overflow=%b required 1", overflow);
    end
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clr: overflow=%b required 0", overflow);
    end
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b1);
    clear_overflow = 1'b1;
    push_byte(8'h30, 1'b0);
    clear_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_err++;
      $display("FAIL clr_vs_set: overflow=%b count=%0d required 1/16", overflow, count);
    end
    cycle();
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_sticky: overflow=%b required 1", overflow);
    end
    drain("clr");
  endtask

  task automatic test_wrap();
    int         sent   = 0;
    int         budget = 2000;
    bit         stall  = 1'b0;
    logic [7:0] held   = 8'h00;
    logic [7:0] b;
    while ((sent < 40 || sb.size() > 0) && budget > 0) begin
      if (stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_err++;
          $display("FAIL wrap_stable: out_valid=%b out_data=%h required 1/%h", out_valid, out_data, held);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'b0;
      b         = 8'h00;
      if (sent < 40 && sb.size() < 16 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hF0 || b == 8'hE0) b = 8'h5A;
        in_data  = b;
        in_valid = 1'b1;
        sent++;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          n_err++;
          $display("FAIL wrap_data: out_data=%h required %h", out_data, (sb.size() > 0) ? sb[0] : 8'hxx);
        end
        if (sb.size() > 0) void'(sb.pop_front());
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (in_valid) sb.push_back(b);
      cycle();
      n_vec++;
      if (count !== 5'(sb.size())) begin
        n_err++;
        $display("FAIL wrap_count: count=%0d required %0d", count, sb.size());
      end
      budget--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (budget == 0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done: empty=%b sent=%0d left=%0d required empty with all 40 drained",
               empty, sent, sb.size());
    end
  endtask

  initial begin
    resetn         = 1'b0;
    in_data        = 8'h00;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    cycle();
    test_reset();
    test_filter();
    test_fill_overflow();
    test_full_push_pop();
    test_clear_overflow();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
